// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide engine: one shift-add or restoring-division step per clock.
// MUL keeps the multiplier in the low half of the accumulator; DIV keeps remainder and quotient apart.
module muldiv_seq #(
    parameter int unsigned N = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         start,
    output logic [N-1:0] result,
    output logic [N-1:0] high,
    output logic         finished,
    output logic         busy,
    output logic         div_zero
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            op_q;
    logic [N-1:0]    opnd_q;     // multiplicand (MUL) or divisor (DIV)
    logic [2*N-1:0]  acc_q;      // MUL product accumulator, multiplier in low half
    logic [N-1:0]    rem_q;
    logic [N-1:0]    quo_q;
    logic [N-1:0]    result_q, high_q;
    logic            div_zero_q;

    logic            div_by_zero;
    logic            last_iter;
    logic [N:0]      sum;
    logic [2*N-1:0]  acc_next;
    logic [N:0]      rem_shift;
    logic            rem_ge;
    logic [N-1:0]    rem_next;
    logic [N-1:0]    quo_next;

    assign div_by_zero = op && (b == '0);
    assign last_iter   = (cnt_q == CW'(N - 1));

    always_comb begin
        sum       = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_next  = {sum, acc_q[N-1:1]};
        rem_shift = {rem_q, quo_q[N-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd_q});
        rem_next  = rem_ge ? N'(rem_shift - {1'b0, opnd_q}) : rem_shift[N-1:0];
        quo_next  = {quo_q[N-2:0], rem_ge};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = div_by_zero ? StDone : StRun;
            StRun:  if (last_iter) state_d = StDone;
            StDone: if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        finished = (state_q == StDone);
        busy     = (state_q == StRun);
        result   = result_q;
        high     = high_q;
        div_zero = div_zero_q;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            high_q     <= '0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q       <= op;
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        div_zero_q <= 1'b0;
                        if (op) begin
                            opnd_q <= b;
                            quo_q  <= a;
                            acc_q  <= '0;
                        end else begin
                            opnd_q <= a;
                            quo_q  <= '0;
                            acc_q  <= {{N{1'b0}}, b};
                        end
                        if (div_by_zero) begin
                            result_q   <= '1;
                            high_q     <= a;
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                    end else begin
                        acc_q <= acc_next;
                    end
                    if (last_iter) begin
                        if (op_q) begin
                            result_q <= quo_next;
                            high_q   <= rem_next;
                        end else begin
                            result_q <= acc_next[N-1:0];
                            high_q   <= acc_next[2*N-1:N];
                        end
                    end
                end
                StDone: begin
                    if (!start) div_zero_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
